// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART frame transmitter. Words arrive over a valid/ready handshake into a
//   one-entry holding register and are shifted out LSB-first as
//   start / data / optional parity / stop bit(s). Bit boundaries are the
//   transitions of baud_clk, a square wave produced in the clk domain.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active low
//   baud_clk  in   baud square wave, synchronous to clk
//   tx_data   in   word to send
//   tx_valid  in   tx_data is valid
//   tx_ready  out  holding register empty
//   tx        out  serial line, idles high
//   busy      out  frame in progress or holding register full
//   tx_done   out  one-cycle pulse at the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic                 baud_q;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 hold_full_q, hold_full_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic                 tx_done_q, tx_done_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;

   logic                 tick;
   logic                 xfer;
   logic                 load;
   logic                 hold_parity;

   // One tick per baud_clk edge, either direction.
   assign tick = baud_clk ^ baud_q;
   assign xfer = tx_valid && !hold_full_q;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   assign hold_parity = (PARITY == 2) ? ~^hold_q : ^hold_q;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      tx_d        = tx_q;
      tx_done_d   = 1'b0;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      load        = 1'b0;

      if (xfer) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  tx_d = 1'b1;
               end
            end
            S_START: begin
               tx_d      = shift_q[0];
               bit_cnt_d = 4'd0;
               state_d   = S_DATA;
            end
            S_DATA: begin
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                     tx_d    = parity_q;
                     state_d = S_PARITY;
                  end else begin
                     tx_d       = 1'b1;
                     stop_cnt_d = 1'b0;
                     state_d    = S_STOP;
                  end
               end else begin
                  // Bit 1 of the current shifter is the next bit on the line.
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            S_PARITY: begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = S_STOP;
            end
            S_STOP: begin
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  tx_done_d = 1'b1;
                  // A queued word starts immediately: no idle gap.
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end

      // Move the holding register into the shifter and begin the start bit.
      if (load) begin
         shift_d     = hold_q;
         parity_d    = hold_parity;
         hold_full_d = 1'b0;
         tx_d        = 1'b0;
         state_d     = S_START;
      end
   end

   always_ff @(posedge clk) begin
      // Sampled during reset too, so leaving reset never yields a false tick.
      baud_q <= baud_clk;
      if (!rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tx_q        <= 1'b1;
         tx_done_q   <= 1'b0;
         bit_cnt_q   <= 4'd0;
         stop_cnt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tx_q        <= tx_d;
         tx_done_q   <= tx_done_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = !hold_full_q;
   assign busy     = (state_q != S_IDLE) || hold_full_q;
   assign tx_done  = tx_done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage fed by the baud clock generator. Accepts parallel words over a valid/ready handshake into a one-entry holding register and shifts them out LSB-first as UART frames: start bit, data, optional parity, stop bit(s). Bit boundaries come from transitions of `baud_clk`, which is generated in the `clk` domain, so one bit time equals the generator's divider in `clk` cycles.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

- `clk`  input  1  system clock (100 MHz).
- `rst`  input  1  reset; one clock; reset is synchronous and active-low.
- `baud_clk`  input  1  square wave from the baud generator, synchronous to `clk`.
- `tx_data`  input  DATA_BITS  word to send.
- `tx_valid`  input  1  `tx_data` is valid.
- `tx_ready`  output  1  holding register empty; a transfer occurs when `tx_valid && tx_ready` on a rising `clk` edge.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  frame in progress or holding register full.
- `tx_done`  output  1  one-cycle pulse at the end of the last stop bit.

## Operation
- Tick detection: `baud_q <= baud_clk` every cycle, including during reset. `tick = baud_clk ^ baud_q`, so there is one tick per `baud_clk` transition. Because `baud_q` also samples during reset, the first cycle after reset never produces a spurious tick.
- Holding register: on a transfer, `hold <= tx_data` and `hold_full <= 1`. `tx_ready = !hold_full`.
- Parity bit: even = XOR of the data bits; odd = inverted XOR. It is computed when the word is loaded into the shifter.
- States and transitions (each transition occurs only on a `tick` cycle; all other cycles hold state):
  - IDLE:
    - If `hold_full`: load the shifter and parity from `hold`, clear `hold_full`, `tx <= 0`, go to START.
    - Otherwise remain in IDLE with `tx = 1`.
  - START: `tx <= shift[0]`, `bit_cnt <= 0`, go to DATA.
  - DATA:
    - If `bit_cnt == DATA_BITS-1`: if `PARITY != 0`, `tx <= parity` and go to PARITY; else `tx <= 1`, `stop_cnt <= 0`, go to STOP.
    - Otherwise shift right, `tx <=` next bit, `bit_cnt++`.
  - PARITY: `tx <= 1`, `stop_cnt <= 0`, go to STOP.
  - STOP:
    - If `stop_cnt == STOP_BITS-1`: pulse `tx_done`. If `hold_full`, load as in IDLE and go to START with no idle gap. Otherwise `tx <= 1` and go to IDLE.
    - Otherwise `stop_cnt++`.
- `busy = (state != IDLE) || hold_full`.

## Timing
- Reset values (`rst` low at a `clk` edge):
  - `state` = IDLE, `tx` = 1, `hold_full` = 0, `tx_ready` = 1, `busy` = 0, `tx_done` = 0, counters = 0.
  - Reset mid-frame aborts the frame: `tx` is high from the next edge and the holding register is discarded.
- `tx` is registered and changes only in the cycle after a `tick`.
- Each bit lasts exactly one tick interval. The frame is 1 + DATA_BITS + (PARITY ? 1 : 0) + STOP_BITS intervals long.
- Accept-to-start latency: from the transfer edge, `tx` falls at the first tick whose cycle is strictly after that edge. This is 1..N cycles, where N is the tick interval.
- Transfer on the same cycle as the final-stop tick: the word is not yet visible (`hold_full` is registered). The machine goes to IDLE, and the start bit begins at the next tick. This is a one-bit idle gap, which is legal.
- `tx_ready` drops the cycle after a transfer. It rises the cycle after the word is loaded into the shifter, so one word can be queued during a frame.
- `tx_valid` while `tx_ready = 0` is ignored; `tx_data` is not sampled.
- `tx_done` is high for exactly one cycle, coincident with the first cycle of the following idle or start bit.

## Test plan
- Reset: hold `rst` low for 3 cycles with `baud_clk` high, then release. Required: `tx` = 1, `tx_ready` = 1, `busy` = 0, and no state change until a real `baud_clk` transition.
- 8N1, 0xA5: bench toggles `baud_clk` every 4 cycles. Required: `tx` sequence per 4-cycle interval is 0,1,0,1,0,0,1,0,1,1; `tx_done` pulses once; then IDLE.
- Parity, 0xA5: `PARITY`=1 gives parity bit 0; `PARITY`=2 gives parity bit 1. With `STOP_BITS`=2, `tx` stays high for 8 cycles before `tx_done`.
- Back-to-back: send 0x55, then send 0x0F while the first frame is in DATA. Required: `tx_ready` = 0 between the second transfer and the second load. The second start bit immediately follows the first stop bit with no idle gap. `busy` stays high throughout.
- Handshake stall: hold `tx_valid` high with changing `tx_data` while `tx_ready` = 0. Required: only the value present at the transfer edge is transmitted.
- Mid-frame reset: assert `rst` during data bit 3 of 0xFF. Required: `tx` = 1 from the next edge, `hold_full` = 0, and the next transfer produces a clean full frame.
